// File: rtl/rsv_port_arbiter_pkg.sv
// Shared constants, state encoding and index helpers for the rsv-stage port arbiter.
package rsv_port_arbiter_pkg;

  localparam int unsigned RSV_NUM_REQ = 6;
  localparam int unsigned RSV_ID_W    = 3;

  typedef enum logic {
    RSV_ARB_IDLE   = 1'b0,
    RSV_ARB_LOCKED = 1'b1
  } rsv_arb_state_e;

  // Binary index of a one-hot vector; 0 for an all-zero vector.
  function automatic logic [RSV_ID_W-1:0] onehotToIdx(input logic [RSV_NUM_REQ-1:0] oh);
    logic [RSV_ID_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < RSV_NUM_REQ; i++) begin
      if (oh[i]) idx = idx | RSV_ID_W'(i);
    end
    return idx;
  endfunction

  // Wrap a non-negative integer into the requester index range.
  function automatic logic [RSV_ID_W-1:0] wrapIdx(input int x);
    return RSV_ID_W'(x % int'(RSV_NUM_REQ));
  endfunction

  // Next-lower index with wrap; used to make the last winner lowest priority.
  function automatic logic [RSV_ID_W-1:0] prevIdx(input logic [RSV_ID_W-1:0] idx);
    return (idx == '0) ? RSV_ID_W'(RSV_NUM_REQ - 1) : idx - RSV_ID_W'(1);
  endfunction

endpackage

// File: rtl/rsv_rot_select.sv
// Rotating-priority selector: index ptr is highest, then ptr-1 down to ptr+1 (wrapping).
module rsv_rot_select
  import rsv_port_arbiter_pkg::*;
(
  input  logic [RSV_NUM_REQ-1:0] vec,
  input  logic [RSV_ID_W-1:0]    ptr,
  output logic [RSV_NUM_REQ-1:0] winner
);

  logic [RSV_NUM_REQ-1:0] rot;
  logic [RSV_NUM_REQ-1:0] pick;
  logic                   found;

  // Rotate so that requester ptr lands on the top bit.
  always_comb begin
    rot = '0;
    for (int k = 0; k < RSV_NUM_REQ; k++) begin
      rot[k] = vec[wrapIdx(int'(ptr) + k + 1)];
    end
  end

  // Highest set bit of the rotated vector.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int k = RSV_NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k] && !found) begin
        pick[k] = 1'b1;
        found   = 1'b1;
      end
    end
  end

  // Rotate the one-hot pick back to requester numbering.
  always_comb begin
    winner = '0;
    for (int k = 0; k < RSV_NUM_REQ; k++) begin
      if (pick[k]) winner[wrapIdx(int'(ptr) + k + 1)] = 1'b1;
    end
  end

endmodule

// File: rtl/rsv_port_arbiter.sv
// Packet-level rotating-priority arbiter for one reservation output port.
// A grant is held from head to tail flit; the winner then drops to lowest priority.
// Optional macro RSV_ARB_TIMEOUT_EN adds a forced release after TIMEOUT_CYC stalled cycles.
module rsv_port_arbiter
  import rsv_port_arbiter_pkg::*;
#(
  parameter int unsigned PTR_RST     = 5,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [RSV_NUM_REQ-1:0] req,
  input  logic [RSV_NUM_REQ-1:0] tail,
  input  logic                   ready,
  output logic [RSV_NUM_REQ-1:0] gnt,
  output logic [RSV_ID_W-1:0]    gnt_id,
  output logic                   locked,
  output logic                   xfer,
  output logic                   timeout
);

  // Reject parameter values outside the supported range at elaboration.
  if (PTR_RST >= RSV_NUM_REQ || TIMEOUT_CYC < 2 || TIMEOUT_CYC > 256) begin : gBadParam
    $error("rsv_port_arbiter: PTR_RST or TIMEOUT_CYC out of range");
  end

  rsv_arb_state_e         state, stateNxt;
  logic [RSV_NUM_REQ-1:0] gntNxt;
  logic [RSV_ID_W-1:0]    ptr, ptrNxt;
  logic [RSV_ID_W-1:0]    relPtr;
  logic [RSV_NUM_REQ-1:0] selVec, selWin;
  logic [RSV_ID_W-1:0]    selPtr;
  logic                   isTail;
  logic                   forceRel;
  logic                   relEvent;

  // Flit accepted by the downstream side for the current holder.
  assign xfer     = locked & (|(gnt & req)) & ready;
  assign isTail   = |(gnt & tail);
  assign relEvent = (xfer & isTail) | forceRel;
  assign relPtr   = prevIdx(gnt_id);

  // Fresh arbitration from IDLE; back-to-back arbitration (holder excluded) on release.
  assign selVec = locked ? (req & ~gnt) : req;
  assign selPtr = locked ? relPtr : ptr;

  rsv_rot_select uSel (
    .vec    (selVec),
    .ptr    (selPtr),
    .winner (selWin)
  );

`ifdef RSV_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);

  logic [CNT_W-1:0] toCnt, toCntNxt;

  assign forceRel = locked & ~xfer & (toCnt == CNT_W'(TIMEOUT_CYC - 1));

  // Count consecutive stalled cycles while a grant is held.
  always_comb begin
    toCntNxt = toCnt + CNT_W'(1);
    if (!locked || xfer || forceRel) toCntNxt = '0;
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) toCnt <= '0;
    else        toCnt <= toCntNxt;
  end
`else
  assign forceRel = 1'b0;
`endif

  assign timeout = forceRel;

  // Next-state, next-grant and pointer update.
  always_comb begin
    stateNxt = state;
    gntNxt   = gnt;
    ptrNxt   = ptr;
    unique case (state)
      RSV_ARB_IDLE: begin
        if (|req) begin
          gntNxt   = selWin;
          stateNxt = RSV_ARB_LOCKED;
        end
      end
      RSV_ARB_LOCKED: begin
        if (relEvent) begin
          ptrNxt = relPtr;
          if (|selVec) begin
            gntNxt = selWin;
          end else begin
            gntNxt   = '0;
            stateNxt = RSV_ARB_IDLE;
          end
        end
      end
      default: begin
        gntNxt   = '0;
        stateNxt = RSV_ARB_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= RSV_ARB_IDLE;
      gnt    <= '0;
      gnt_id <= '0;
      locked <= 1'b0;
      ptr    <= RSV_ID_W'(PTR_RST);
    end else begin
      state  <= stateNxt;
      gnt    <= gntNxt;
      gnt_id <= onehotToIdx(gntNxt);
      locked <= (stateNxt == RSV_ARB_LOCKED);
      ptr    <= ptrNxt;
    end
  end

endmodule

// File: doc/rsv_port_arbiter.md
Name: rsv_port_arbiter

Overview:
- Packet-level arbiter sharing one reservation output port among 6 requesters in the deflection router's rsv stage.
- Uses rotating priority: the rotated request vector feeds a 6-bit highest-bit one-hot selector, and the result is rotated back.
- A grant is locked from the head flit to the tail flit, then the pointer advances so the last winner becomes lowest priority.
- Sits between input-port request logic and the output crossbar select.

Parameters:
- PTR_RST, 5, reset value of the priority pointer (0..5); index PTR_RST has highest priority after reset.
- TIMEOUT_CYC, 64, maximum consecutive no-transfer cycles while locked (used only with RSV_ARB_TIMEOUT_EN); legal range 2..256.

Ports:
- clk  in  1  Single clock, rising edge.
- reset  in  1  Asynchronous, active-low reset (asserted at 0).
- req  in  6  Per-requester flit valid; bit i means requester i has a flit for this port.
- tail  in  6  Per-requester tail flag; qualified by req[i]. A single-flit packet has head and tail in the same flit.
- ready  in  1  Downstream can accept a flit this cycle.
- gnt  out  6  Registered one-hot grant; all zero when idle.
- gnt_id  out  3  Binary index of the granted requester; 0 when idle.
- locked  out  1  1 while a grant is held (state LOCKED).
- xfer  out  1  Combinational: locked & req[w] & ready, where w is the granted index.
- timeout  out  1  One-cycle pulse when a forced release occurs; tied 0 without the macro.

Behaviour:
- Reset (async assert): gnt=0, gnt_id=0, locked=0, timeout=0, ptr=PTR_RST, state=IDLE, timeout counter=0. Deassertion is used synchronously.
- Priority order for pointer p: p, p-1, ..., 0, 5, ..., p+1 (descending, wrapping).
- Selector: form rot[k] = v[(p+k+1) mod 6], take the highest set bit of rot, and map it back to a one-hot index. The function is pure combinational.
- IDLE state:
  - If |req: on the next edge, gnt <= select(req, ptr) and state goes to LOCKED.
  - Otherwise remain idle.
  - Latency is one cycle from req to gnt.
  - ready does not affect granting.
- LOCKED state, granted index w:
  - Transfer: xfer=1 when req[w] & ready. No transfer when req[w]=0 or ready=0; the grant is held and the other requesters stall.
  - Release: xfer & tail[w]. On release, ptr <= (w+5) mod 6, so w becomes lowest priority.
  - Back-to-back on release: m = req & ~gnt. If |m, gnt <= select(m, (w+5) mod 6) and the state stays LOCKED, with no bubble. Otherwise gnt <= 0 and the state goes to IDLE.
  - Requester w cannot re-win in its release cycle. It can win from IDLE on the next cycle.
- Simultaneous events:
  - New requests arriving during LOCKED are ignored until release.
  - A tail with ready=0 does not release.
  - req[w] dropping mid-packet holds the lock (protocol error, no recovery unless the macro is enabled).
- Reset mid-packet: grant is cleared immediately and the partial packet is abandoned. The upstream side is responsible for flushing.
- gnt_id is always the encode of gnt. locked == |gnt.

Optional Feature:
- Macro: RSV_ARB_TIMEOUT_EN.
- When defined:
  - A counter of width clog2(TIMEOUT_CYC) clears on IDLE and on every xfer, and increments in each LOCKED cycle without xfer.
  - When it reaches TIMEOUT_CYC-1 in a no-xfer cycle, a forced release occurs exactly like a tail release (pointer advance, back-to-back arbitration), timeout pulses for that cycle, and the counter clears.
- When undefined: no counter is built, timeout is constant 0, and the lock is held indefinitely.

Decomposition:
- Shared global include: RSV_NUM_REQ=6, RSV_ID_W=3, state encodings RSV_ARB_IDLE/RSV_ARB_LOCKED, and the onehot-to-index encode function.
- Sub-module rsv_rot_select: inputs are a 6-bit vector and a 3-bit pointer; output is a one-hot winner. It contains the rotate, highest-bit select and unrotate logic, is combinational, and is instantiated once.

Test Plan:
- Reset, then req=6'b000001, tail=6'b000001, ready=1. Next cycle gnt=000001, gnt_id=0, xfer=1. Following cycle gnt=0 and ptr=5.
- After reset (ptr=5), req=6'b100001 with 3-flit packets. Requester 5 wins, then requester 0 is granted in the cycle after 5's tail with no idle gap. ptr=5 after 0's tail.
- Lock hold: grant to 2, and req[4] rises mid-packet. gnt stays 000100 until tail[2]&ready, then gnt=010000.
- Backpressure: tail[3]=1 with ready=0 for 5 cycles, gnt stays 001000 and xfer=0. The release happens on the first ready=1.
- Async reset asserted while locked on requester 1 (mid-packet). Outputs go to 0 immediately, without a clock. After deassertion, req=6'b111111 grants index 5.
- With RSV_ARB_TIMEOUT_EN and TIMEOUT_CYC=4: grant to 0, then req[0]=0 for 4 cycles. timeout pulses in the 4th no-xfer cycle, gnt goes to 0, and ptr=5.
